rr_cfg_axil_interconnect: RTL and testbench

- 1-slave-port to 2-master-port AXI4-Lite interconnect on the BAR1 config path.
- Splits a 2 MB window: low 1 MB (addr bit 20 = 0) goes to M00, the user-logic BAR1 pass-through; high 1 MB (bit 20 = 1) goes to M01, the record/replay config registers.
- Registered on every channel; one outstanding write and one outstanding read, serviced independently.

---
 rtl/rr_cfg_axil_interconnect_pkg.sv | 13 +
 rtl/rr_cfg_axil_interconnect_if.sv | 38 +++
 rtl/rr_cfg_axil_interconnect_addr_decode.sv | 18 +
 rtl/rr_cfg_axil_interconnect.sv | 182 ++++++++++++++++++
 tb/tb_rr_cfg_axil_interconnect.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_cfg_axil_interconnect_pkg.sv
// Shared types and constants for the BAR1 config-path AXI4-Lite 1:2 interconnect.
package rr_cfg_axil_ic_pkg;

    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAITB, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAITR, R_RESP} rd_state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int DEFAULT_SPLIT_BIT = 20;

endpackage

// File: rtl/rr_cfg_axil_interconnect_if.sv
// AXI4-Lite bundle; master modport drives requests, slave modport drives responses.
interface rr_cfg_axil_interconnect_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/rr_cfg_axil_interconnect_addr_decode.sv
// Address decode: bit 0 of addr_hi is the split bit; with RR_CFG_AXIL_DECERR_EN any higher bit flags DECERR.
module rr_axil_addr_decode #(
    parameter int DEC_W = 1
) (
    input  logic [DEC_W-1:0] addr_hi,
    output logic             tgt,
    output logic             decerr
);

    assign tgt = addr_hi[0];

`ifdef RR_CFG_AXIL_DECERR_EN
    assign decerr = |(addr_hi >> 1);
`else
    assign decerr = 1'b0;
`endif

endmodule

// File: rtl/rr_cfg_axil_interconnect.sv
// 1:2 AXI4-Lite interconnect: addr[SPLIT_BIT]=0 -> M00 (user BAR1), =1 -> M01 (record/replay regs).
// Optional RR_CFG_AXIL_DECERR_EN: addresses above the 2^(SPLIT_BIT+1) window answer DECERR locally.
module rr_cfg_axil_interconnect
    import rr_cfg_axil_ic_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SPLIT_BIT  = DEFAULT_SPLIT_BIT
) (
    input logic                   ACLK,
    input logic                   ARESETN,
    rr_cfg_axil_interconnect_if.slave  s00_axi,
    rr_cfg_axil_interconnect_if.master m00_axi,
    rr_cfg_axil_interconnect_if.master m01_axi
);

    localparam int STRB_W = DATA_WIDTH / 8;
`ifdef RR_CFG_AXIL_DECERR_EN
    localparam int DEC_W = ADDR_WIDTH - SPLIT_BIT;
`else
    localparam int DEC_W = 1;
`endif

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;

    logic                  up;
    logic                  aw_full, w_full, aw_sent, w_sent;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [2:0]            aw_prot, ar_prot;
    logic [DATA_WIDTH-1:0] w_data, r_data;
    logic [STRB_W-1:0]     w_strb;
    logic [1:0]            b_resp, r_resp;

    logic [DEC_W-1:0] aw_hi, ar_hi;
    logic             wr_tgt, wr_decerr, rd_tgt, rd_decerr;
    logic             aw_hs, w_hs, ar_hs, maw_hs, mw_hs, mb_hs, mar_hs, mr_hs;
    logic             awvalid_i, wvalid_i, bready_i, arvalid_i, rready_i;

    // Decode the address about to be captured in IDLE, the held one afterwards.
    assign aw_hi = aw_full ? aw_addr[SPLIT_BIT +: DEC_W] : s00_axi.awaddr[SPLIT_BIT +: DEC_W];
    assign ar_hi = (r_state == R_IDLE) ? s00_axi.araddr[SPLIT_BIT +: DEC_W] : ar_addr[SPLIT_BIT +: DEC_W];

    rr_axil_addr_decode #(.DEC_W(DEC_W)) u_wr_dec (.addr_hi(aw_hi), .tgt(wr_tgt), .decerr(wr_decerr));
    rr_axil_addr_decode #(.DEC_W(DEC_W)) u_rd_dec (.addr_hi(ar_hi), .tgt(rd_tgt), .decerr(rd_decerr));

    // up keeps S00 readys low while reset is asserted.
    assign s00_axi.awready = up & (w_state == W_IDLE) & ~aw_full;
    assign s00_axi.wready  = up & (w_state == W_IDLE) & ~w_full;
    assign s00_axi.arready = up & (r_state == R_IDLE);
    assign s00_axi.bvalid  = (w_state == W_RESP);
    assign s00_axi.bresp   = b_resp;
    assign s00_axi.rvalid  = (r_state == R_RESP);
    assign s00_axi.rdata   = r_data;
    assign s00_axi.rresp   = r_resp;

    assign aw_hs = s00_axi.awvalid & s00_axi.awready;
    assign w_hs  = s00_axi.wvalid  & s00_axi.wready;
    assign ar_hs = s00_axi.arvalid & s00_axi.arready;

    assign awvalid_i = (w_state == W_ISSUE) & ~aw_sent;
    assign wvalid_i  = (w_state == W_ISSUE) & ~w_sent;
    assign bready_i  = (w_state == W_WAITB);
    assign arvalid_i = (r_state == R_ISSUE);
    assign rready_i  = (r_state == R_WAITR);

    assign maw_hs = awvalid_i & (wr_tgt ? m01_axi.awready : m00_axi.awready);
    assign mw_hs  = wvalid_i  & (wr_tgt ? m01_axi.wready  : m00_axi.wready);
    assign mb_hs  = bready_i  & (wr_tgt ? m01_axi.bvalid  : m00_axi.bvalid);
    assign mar_hs = arvalid_i & (rd_tgt ? m01_axi.arready : m00_axi.arready);
    assign mr_hs  = rready_i  & (rd_tgt ? m01_axi.rvalid  : m00_axi.rvalid);

    assign m00_axi.awvalid = awvalid_i & ~wr_tgt;
    assign m01_axi.awvalid = awvalid_i &  wr_tgt;
    assign m00_axi.wvalid  = wvalid_i  & ~wr_tgt;
    assign m01_axi.wvalid  = wvalid_i  &  wr_tgt;
    assign m00_axi.bready  = bready_i  & ~wr_tgt;
    assign m01_axi.bready  = bready_i  &  wr_tgt;
    assign m00_axi.arvalid = arvalid_i & ~rd_tgt;
    assign m01_axi.arvalid = arvalid_i &  rd_tgt;
    assign m00_axi.rready  = rready_i  & ~rd_tgt;
    assign m01_axi.rready  = rready_i  &  rd_tgt;

    assign m00_axi.awaddr = aw_addr;
    assign m01_axi.awaddr = aw_addr;
    assign m00_axi.awprot = aw_prot;
    assign m01_axi.awprot = aw_prot;
    assign m00_axi.wdata  = w_data;
    assign m01_axi.wdata  = w_data;
    assign m00_axi.wstrb  = w_strb;
    assign m01_axi.wstrb  = w_strb;
    assign m00_axi.araddr = ar_addr;
    assign m01_axi.araddr = ar_addr;
    assign m00_axi.arprot = ar_prot;
    assign m01_axi.arprot = ar_prot;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if ((aw_full | aw_hs) && (w_full | w_hs)) w_next = wr_decerr ? W_RESP : W_ISSUE;
            W_ISSUE: if ((aw_sent | maw_hs) && (w_sent | mw_hs)) w_next = W_WAITB;
            W_WAITB: if (mb_hs) w_next = W_RESP;
            W_RESP:  if (s00_axi.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = rd_decerr ? R_RESP : R_ISSUE;
            R_ISSUE: if (mar_hs) r_next = R_WAITR;
            R_WAITR: if (mr_hs) r_next = R_RESP;
            R_RESP:  if (s00_axi.rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            up      <= 1'b0;
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_sent <= 1'b0;
            w_sent  <= 1'b0;
            aw_addr <= '0;
            aw_prot <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            b_resp  <= '0;
            ar_addr <= '0;
            ar_prot <= '0;
            r_data  <= '0;
            r_resp  <= '0;
        end else begin
            up <= 1'b1;
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_addr <= s00_axi.awaddr;
                aw_prot <= s00_axi.awprot;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= s00_axi.wdata;
                w_strb <= s00_axi.wstrb;
            end
            if (maw_hs) aw_sent <= 1'b1;
            if (mw_hs)  w_sent  <= 1'b1;
            if (w_state == W_IDLE && w_next == W_RESP) b_resp <= DECERR;
            if (mb_hs) b_resp <= wr_tgt ? m01_axi.bresp : m00_axi.bresp;
            if (w_state == W_RESP && s00_axi.bready) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                aw_sent <= 1'b0;
                w_sent  <= 1'b0;
            end
            if (ar_hs) begin
                ar_addr <= s00_axi.araddr;
                ar_prot <= s00_axi.arprot;
            end
            if (r_state == R_IDLE && r_next == R_RESP) begin
                r_data <= '0;
                r_resp <= DECERR;
            end
            if (mr_hs) begin
                r_data <= rd_tgt ? m01_axi.rdata : m00_axi.rdata;
                r_resp <= rd_tgt ? m01_axi.rresp : m00_axi.rresp;
            end
        end
    end

endmodule

// File: tb/tb_rr_cfg_axil_interconnect.sv
// Bench for rr_cfg_axil_interconnect: vector table plus hand sequences, responses checked via scoreboard queues.
module tb_rr_cfg_axil_interconnect;
    import rr_cfg_axil_ic_pkg::*;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    rr_cfg_axil_interconnect_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s00 ();
    rr_cfg_axil_interconnect_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m00 ();
    rr_cfg_axil_interconnect_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m01 ();

    rr_cfg_axil_interconnect dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .s00_axi(s00), .m00_axi(m00), .m01_axi(m01)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  sresp;
        bit          exp_tgt;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
    } sb_t;

    int   total = 0;
    int   bad = 0;
    sb_t  wq[$];
    sb_t  rq[$];
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge ACLK);
    endtask

    // {awvalid, wvalid, bready, arvalid, rready} of one master port
    function automatic logic [4:0] mstat(input bit t);
        if (t) return {m01.awvalid, m01.wvalid, m01.bready, m01.arvalid, m01.rready};
        return {m00.awvalid, m00.wvalid, m00.bready, m00.arvalid, m00.rready};
    endfunction

    function automatic logic [31:0] m_awaddr(input bit t); return t ? m01.awaddr : m00.awaddr; endfunction
    function automatic logic [31:0] m_wdata(input bit t);  return t ? m01.wdata  : m00.wdata;  endfunction
    function automatic logic [3:0]  m_wstrb(input bit t);  return t ? m01.wstrb  : m00.wstrb;  endfunction
    function automatic logic [31:0] m_araddr(input bit t); return t ? m01.araddr : m00.araddr; endfunction
    function automatic logic [2:0]  m_awprot(input bit t); return t ? m01.awprot : m00.awprot; endfunction

    task automatic set_rdy(input bit t, input logic aw, input logic w, input logic ar);
        if (t) begin m01.awready = aw; m01.wready = w; m01.arready = ar; end
        else   begin m00.awready = aw; m00.wready = w; m00.arready = ar; end
    endtask

    task automatic set_b(input bit t, input logic v, input logic [1:0] r);
        if (t) begin m01.bvalid = v; m01.bresp = r; end
        else   begin m00.bvalid = v; m00.bresp = r; end
    endtask

    task automatic set_r(input bit t, input logic v, input logic [31:0] d, input logic [1:0] r);
        if (t) begin m01.rvalid = v; m01.rdata = d; m01.rresp = r; end
        else   begin m00.rvalid = v; m00.rdata = d; m00.rresp = r; end
    endtask

    task automatic pop_b();
        sb_t e;
        if (wq.size() == 0) begin
            total++; bad++;
            $display("FAIL wq_empty: got bresp %h, want none pending", s00.bresp);
        end else begin
            e = wq.pop_front();
            chk("s00_bresp", {30'd0, s00.bresp}, {30'd0, e.resp});
        end
    endtask

    task automatic pop_r();
        sb_t e;
        if (rq.size() == 0) begin
            total++; bad++;
            $display("FAIL rq_empty: got rdata %h, want none pending", s00.rdata);
        end else begin
            e = rq.pop_front();
            chk("s00_rresp", {30'd0, s00.rresp}, {30'd0, e.resp});
            chk("s00_rdata", s00.rdata, e.rdata);
        end
    endtask

    task automatic run_vec(input vec_t v);
        if (v.wr) begin
            chk("awready_idle", {31'd0, s00.awready}, 32'd1);
            s00.awaddr = v.addr; s00.awprot = 3'b010; s00.awvalid = 1'b1;
            s00.wdata = v.data; s00.wstrb = v.strb; s00.wvalid = 1'b1;
            wq.push_back('{resp: v.exp_resp, rdata: 32'h0});
            step();
            s00.awvalid = 1'b0; s00.wvalid = 1'b0;
            chk("wr_issue", {27'd0, mstat(v.exp_tgt)}, 32'h18);
            chk("wr_other_idle", {27'd0, mstat(!v.exp_tgt)}, 32'h0);
            chk("m_awaddr", m_awaddr(v.exp_tgt), v.addr);
            chk("m_awprot", {29'd0, m_awprot(v.exp_tgt)}, 32'd2);
            chk("m_wdata", m_wdata(v.exp_tgt), v.data);
            chk("m_wstrb", {28'd0, m_wstrb(v.exp_tgt)}, {28'd0, v.strb});
            set_rdy(v.exp_tgt, 1, 1, 0);
            step();
            set_rdy(v.exp_tgt, 0, 0, 0);
            chk("wr_waitb", {27'd0, mstat(v.exp_tgt)}, 32'h04);
            set_b(v.exp_tgt, 1, v.sresp);
            step();
            set_b(v.exp_tgt, 0, 2'b00);
            chk("s00_bvalid", {31'd0, s00.bvalid}, 32'd1);
            pop_b();
            s00.bready = 1'b1;
            step();
            s00.bready = 1'b0;
            chk("wr_done", {30'd0, s00.bvalid, s00.awready}, 32'd1);
        end else begin
            chk("arready_idle", {31'd0, s00.arready}, 32'd1);
            s00.araddr = v.addr; s00.arprot = 3'b001; s00.arvalid = 1'b1;
            rq.push_back('{resp: v.exp_resp, rdata: v.exp_rdata});
            step();
            s00.arvalid = 1'b0;
            chk("rd_issue", {27'd0, mstat(v.exp_tgt)}, 32'h02);
            chk("rd_other_idle", {27'd0, mstat(!v.exp_tgt)}, 32'h0);
            chk("m_araddr", m_araddr(v.exp_tgt), v.addr);
            set_rdy(v.exp_tgt, 0, 0, 1);
            step();
            set_rdy(v.exp_tgt, 0, 0, 0);
            chk("rd_waitr", {27'd0, mstat(v.exp_tgt)}, 32'h01);
            set_r(v.exp_tgt, 1, v.data, v.sresp);
            step();
            set_r(v.exp_tgt, 0, 32'h0, 2'b00);
            chk("s00_rvalid", {31'd0, s00.rvalid}, 32'd1);
            pop_r();
            s00.rready = 1'b1;
            step();
            s00.rready = 1'b0;
            chk("rd_done", {30'd0, s00.rvalid, s00.arready}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want test end");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va;
        s00.awaddr = '0; s00.awprot = '0; s00.awvalid = 0; s00.wdata = '0; s00.wstrb = '0;
        s00.wvalid = 0; s00.bready = 0; s00.araddr = '0; s00.arprot = '0; s00.arvalid = 0;
        s00.rready = 0;
        m00.awready = 0; m00.wready = 0; m00.bresp = 0; m00.bvalid = 0; m00.arready = 0;
        m00.rdata = 0; m00.rresp = 0; m00.rvalid = 0;
        m01.awready = 0; m01.wready = 0; m01.bresp = 0; m01.bvalid = 0; m01.arready = 0;
        m01.rdata = 0; m01.rresp = 0; m01.rvalid = 0;

        vecs[0] = '{wr:1, addr:32'h0000_0010, data:32'hDEAD_BEEF, strb:4'hF, sresp:OKAY,
                    exp_tgt:0, exp_resp:OKAY, exp_rdata:32'h0};
        vecs[1] = '{wr:0, addr:32'h0010_0004, data:32'h1234_5678, strb:4'h0, sresp:OKAY,
                    exp_tgt:1, exp_resp:OKAY, exp_rdata:32'h1234_5678};
        vecs[2] = '{wr:1, addr:32'h0010_0020, data:32'h0000_A5A5, strb:4'h3, sresp:SLVERR,
                    exp_tgt:1, exp_resp:SLVERR, exp_rdata:32'h0};
        vecs[3] = '{wr:0, addr:32'h0000_0FFC, data:32'hCAFE_F00D, strb:4'h0, sresp:SLVERR,
                    exp_tgt:0, exp_resp:SLVERR, exp_rdata:32'hCAFE_F00D};
        vecs[4] = '{wr:1, addr:32'h000F_FFFC, data:32'h0102_0304, strb:4'h8, sresp:OKAY,
                    exp_tgt:0, exp_resp:OKAY, exp_rdata:32'h0};
        vecs[5] = '{wr:0, addr:32'h001F_FFFC, data:32'h89AB_CDEF, strb:4'h0, sresp:OKAY,
                    exp_tgt:1, exp_resp:OKAY, exp_rdata:32'h89AB_CDEF};

        // reset state
        #1;
        chk("rst_s_ready", {29'd0, s00.awready, s00.wready, s00.arready}, 32'd0);
        chk("rst_s_valid", {30'd0, s00.bvalid, s00.rvalid}, 32'd0);
        chk("rst_m_stat", {22'd0, mstat(0), mstat(1)}, 32'd0);
        step(); step();
        ARESETN = 1'b1;
        step();
        chk("post_rst_ready", {29'd0, s00.awready, s00.wready, s00.arready}, 32'd7);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // W three cycles ahead of AW; second AW held off until B completes
        s00.wdata = 32'h55AA_55AA; s00.wstrb = 4'hF; s00.wvalid = 1'b1;
        wq.push_back('{resp: OKAY, rdata: 32'h0});
        step();
        s00.wvalid = 1'b0;
        chk("w_first_wready", {31'd0, s00.wready}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            chk("w_first_no_issue", {22'd0, mstat(0), mstat(1)}, 32'd0);
            step();
        end
        chk("w_first_no_issue", {22'd0, mstat(0), mstat(1)}, 32'd0);
        s00.awaddr = 32'h0010_0000; s00.awprot = 3'b000; s00.awvalid = 1'b1;
        step();
        chk("late_aw_issue", {27'd0, mstat(1)}, 32'h18);
        chk("late_aw_addr", m01.awaddr, 32'h0010_0000);
        chk("late_aw_wdata", m01.wdata, 32'h55AA_55AA);
        s00.awaddr = 32'h0000_0010;
        m01.awready = 1'b1;
        step();
        m01.awready = 1'b0;
        chk("aw_drop_w_hold", {27'd0, mstat(1)}, 32'h08);
        chk("aw2_refused", {31'd0, s00.awready}, 32'd0);
        m01.wready = 1'b1;
        step();
        m01.wready = 1'b0;
        chk("late_waitb", {27'd0, mstat(1)}, 32'h04);
        chk("aw2_refused", {31'd0, s00.awready}, 32'd0);
        set_b(1, 1, OKAY);
        step();
        set_b(1, 0, OKAY);
        chk("late_bvalid", {30'd0, s00.bvalid, s00.awready}, 32'd2);
        pop_b();
        s00.bready = 1'b1;
        step();
        s00.bready = 1'b0;
        chk("aw_ready_again", {30'd0, s00.bvalid, s00.awready}, 32'd1);
        s00.awvalid = 1'b0;
        step();

        // concurrent write to M00 and read from M01, S00 rready held off
        s00.awaddr = 32'h0000_0100; s00.awvalid = 1'b1;
        s00.wdata = 32'h1111_2222; s00.wstrb = 4'hF; s00.wvalid = 1'b1;
        s00.araddr = 32'h0010_0008; s00.arvalid = 1'b1;
        wq.push_back('{resp: OKAY, rdata: 32'h0});
        rq.push_back('{resp: OKAY, rdata: 32'h0BAD_C0DE});
        step();
        s00.awvalid = 1'b0; s00.wvalid = 1'b0; s00.arvalid = 1'b0;
        chk("cc_m00", {27'd0, mstat(0)}, 32'h18);
        chk("cc_m01", {27'd0, mstat(1)}, 32'h02);
        set_rdy(0, 1, 1, 0);
        set_rdy(1, 0, 0, 1);
        step();
        set_rdy(0, 0, 0, 0);
        set_rdy(1, 0, 0, 0);
        chk("cc_wait", {22'd0, mstat(0), mstat(1)}, 32'h81);
        set_r(1, 1, 32'h0BAD_C0DE, OKAY);
        set_b(0, 1, OKAY);
        step();
        set_r(1, 0, 32'h0, OKAY);
        set_b(0, 0, OKAY);
        chk("cc_s_valid", {30'd0, s00.bvalid, s00.rvalid}, 32'd3);
        pop_b();
        s00.bready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("cc_rvalid_hold", {31'd0, s00.rvalid}, 32'd1);
            chk("cc_rdata_hold", s00.rdata, 32'h0BAD_C0DE);
            step();
            if (i == 0) begin
                s00.bready = 1'b0;
                chk("cc_b_indep", {31'd0, s00.bvalid}, 32'd0);
            end
        end
        pop_r();
        s00.rready = 1'b1;
        step();
        s00.rready = 1'b0;
        chk("cc_r_done", {31'd0, s00.rvalid}, 32'd0);

        // reset while M01 bvalid pending
        s00.awaddr = 32'h0010_0000; s00.awvalid = 1'b1;
        s00.wdata = 32'h7777_7777; s00.wvalid = 1'b1;
        step();
        s00.awvalid = 1'b0; s00.wvalid = 1'b0;
        set_rdy(1, 1, 1, 0);
        step();
        set_rdy(1, 0, 0, 0);
        set_b(1, 1, SLVERR);
        #2 ARESETN = 1'b0;
        #1;
        chk("rst_mid_bvalid", {31'd0, s00.bvalid}, 32'd0);
        chk("rst_mid_mstat", {22'd0, mstat(0), mstat(1)}, 32'd0);
        chk("rst_mid_ready", {29'd0, s00.awready, s00.wready, s00.arready}, 32'd0);
        wq.delete();
        step();
        set_b(1, 0, OKAY);
        step();
        ARESETN = 1'b1;
        step();
        chk("rst_rel_ready", {29'd0, s00.awready, s00.wready, s00.arready}, 32'd7);
        chk("rst_rel_idle", {20'd0, s00.bvalid, s00.rvalid, mstat(0), mstat(1)}, 32'd0);

`ifdef RR_CFG_AXIL_DECERR_EN
        s00.araddr = 32'h0020_0000; s00.arvalid = 1'b1;
        rq.push_back('{resp: DECERR, rdata: 32'h0});
        step();
        s00.arvalid = 1'b0;
        chk("dec_rd_no_fwd", {22'd0, mstat(0), mstat(1)}, 32'd0);
        chk("dec_rvalid", {31'd0, s00.rvalid}, 32'd1);
        pop_r();
        s00.rready = 1'b1;
        step();
        s00.rready = 1'b0;
        chk("dec_r_done", {31'd0, s00.rvalid}, 32'd0);
        s00.awaddr = 32'h4000_0010; s00.awvalid = 1'b1;
        s00.wdata = 32'h9999_0000; s00.wvalid = 1'b1;
        wq.push_back('{resp: DECERR, rdata: 32'h0});
        step();
        s00.awvalid = 1'b0; s00.wvalid = 1'b0;
        chk("dec_wr_no_fwd", {22'd0, mstat(0), mstat(1)}, 32'd0);
        chk("dec_bvalid", {31'd0, s00.bvalid}, 32'd1);
        pop_b();
        s00.bready = 1'b1;
        step();
        s00.bready = 1'b0;
        chk("dec_b_done", {30'd0, s00.bvalid, s00.awready}, 32'd1);
`else
        // upper address bits alias; only the split bit steers
        va = '{wr:1, addr:32'h8010_0000, data:32'h0BB0_0BB0, strb:4'hF, sresp:OKAY,
               exp_tgt:1, exp_resp:OKAY, exp_rdata:32'h0};
        run_vec(va);
        va = '{wr:0, addr:32'h0020_0000, data:32'h3C3C_3C3C, strb:4'h0, sresp:OKAY,
               exp_tgt:0, exp_resp:OKAY, exp_rdata:32'h3C3C_3C3C};
        run_vec(va);
`endif

        chk("sb_drained", wq.size() + rq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
